semaphore_timer: RTL and testbench
==================================

SEMAPHORE_TIMER -- requirements
Module: semaphore_timer

Interface
REQ-001 Parameter TICK_CYCLES, default 50000000, clock cycles per one-second tick (range 2..2^26).
REQ-002 Parameter T_PGREEN, default 30, principal-green duration in seconds (1..255).
REQ-003 Parameter T_SGREEN, default 20, secondary-green duration in seconds (1..255).
REQ-004 Parameter T_YELLOW, default 4, yellow duration in seconds (1..255).
REQ-005 Parameter T_AUX, default 2, auxiliary (all-red clearance) duration in seconds (1..255).
REQ-006 Port clock input 1, rising-edge clock for all state.
REQ-007 Port reset input 1, asynchronous, active-high.
REQ-008 Port TimerMux input 2, phase-duration select driven by the semaphore controller.
REQ-009 Port enable input 1, high = timing runs, low = prescaler and counter frozen.
REQ-010 Port trigger output 1, registered one-cycle pulse, phase time expired.
REQ-011 Port Remaining output 8, seconds left in the current phase.
REQ-012 Port TimerState output 2, current FSM state for debug.

Function
REQ-013 Duration map SHALL be 2'b00->T_PGREEN, 2'b01->T_SGREEN, 2'b10->T_YELLOW, 2'b11->T_AUX; a parameter value of 0 SHALL be treated as 1.
REQ-014 FSM SHALL have states LOAD(0), COUNT(1), FIRE(2); encoding 3 SHALL return to LOAD.
REQ-015 LOAD: Remaining <= duration(TimerMux), sel_q <= TimerMux, prescaler <= 0, next state COUNT, regardless of enable.
REQ-016 COUNT: when enable high, prescaler SHALL count 0..TICK_CYCLES-1 and wrap; tick = enable and prescaler==TICK_CYCLES-1.
REQ-017 COUNT: on tick, Remaining SHALL decrement by 1; on tick with Remaining==1, next state FIRE (Remaining becomes 0).
REQ-018 COUNT: if TimerMux != sel_q, next state LOAD (phase restart), no trigger, and this SHALL take priority over a coincident tick.
REQ-019 FIRE: trigger SHALL be 1 for exactly this one cycle, then LOAD unconditionally; enable low SHALL NOT suppress or extend FIRE.
REQ-020 trigger SHALL be 0 in LOAD and COUNT; it SHALL be a decoded registered state, never combinational from inputs.
REQ-021 The LOAD following FIRE SHALL sample TimerMux, so the controller's next-phase select (asserted in the FIRE cycle and held in the following state) is the one loaded.
REQ-022 Period from LOAD to next LOAD with enable held high SHALL be exactly D*TICK_CYCLES+2 cycles, D = selected duration.
REQ-023 enable low in COUNT SHALL hold prescaler, Remaining and state; TimerMux change SHALL still restart via REQ-018.
REQ-024 Remaining SHALL never underflow; it SHALL read 0 only in FIRE and reset.

Reset
REQ-025 reset high SHALL asynchronously force state LOAD, prescaler 0, Remaining 0, sel_q 2'b00, trigger 0, TimerState 0.
REQ-026 Reset asserted mid-COUNT or in FIRE SHALL abort the phase with no trigger; first edge after release performs LOAD.

Structure
REQ-027 Package semaphore_pkg SHALL hold TimerMux encodings (TM_PGREEN 2'b00, TM_SGREEN 2'b01, TM_YELLOW 2'b10, TM_AUX 2'b11) and the timer state encodings, shared with the controller.
REQ-028 The prescaler SHALL be sub-module tick_prescaler (inputs clock, reset, clear, enable; output tick), parameterised by TICK_CYCLES.

Verification (TICK_CYCLES=4, T_PGREEN=3, T_SGREEN=2, T_YELLOW=1, T_AUX=1)
REQ-029 Reset release, TimerMux=00, enable=1 -> trigger high only in cycle 13 after release (edge count from release), then every 14 cycles; Remaining 3,2,1,0 at 4-cycle steps.
REQ-030 Closed loop with the semaphore controller -> phase sequence 00,10,01,10,00 with durations 14,6,10,6 cycles, exactly one trigger pulse per phase.
REQ-031 TimerMux changed 00->01 mid-COUNT with Remaining=2 -> no trigger, LOAD next cycle, Remaining=2, trigger 10 cycles later.
REQ-032 enable low for 7 cycles during COUNT -> Remaining and prescaler frozen, trigger delayed by exactly 7 cycles; enable low in FIRE -> pulse still 1 cycle.
REQ-033 reset asserted in FIRE cycle -> trigger drops immediately, all outputs 0, no further trigger until a full new period.
REQ-034 T_YELLOW=0 override, TimerMux=10 -> behaves as 1 second, period 6 cycles.

Source files
------------

// File: rtl/semaphore_pkg.sv
// Shared encodings between the semaphore controller and its phase timer.
package semaphore_pkg;

    typedef enum logic [1:0] {
        TM_PGREEN = 2'b00,
        TM_SGREEN = 2'b01,
        TM_YELLOW = 2'b10,
        TM_AUX    = 2'b11
    } timer_mux_t;

    typedef enum logic [1:0] {
        TS_LOAD  = 2'b00,
        TS_COUNT = 2'b01,
        TS_FIRE  = 2'b10
    } timer_state_t;

    // A zero-second phase would never fire, so it is stretched to one second.
    function automatic logic [7:0] phase_seconds(input int unsigned secs);
        return (secs == 0) ? 8'd1 : secs[7:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into one-second ticks; frozen while enable is low.
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/semaphore_timer.sv
// Phase timer for the semaphore controller: loads the selected phase duration,
// counts it down in seconds and emits a one-cycle trigger when it expires.
module semaphore_timer
    import semaphore_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50000000,
    parameter int unsigned T_PGREEN    = 30,
    parameter int unsigned T_SGREEN    = 20,
    parameter int unsigned T_YELLOW    = 4,
    parameter int unsigned T_AUX       = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] TimerMux,
    input  logic       enable,
    output logic       trigger,
    output logic [7:0] Remaining,
    output logic [1:0] TimerState
);

    localparam logic [7:0] D_PGREEN = phase_seconds(T_PGREEN);
    localparam logic [7:0] D_SGREEN = phase_seconds(T_SGREEN);
    localparam logic [7:0] D_YELLOW = phase_seconds(T_YELLOW);
    localparam logic [7:0] D_AUX    = phase_seconds(T_AUX);

    timer_state_t state;
    logic [1:0]   sel_q;
    logic [7:0]   load_secs;
    logic         tick;
    logic         clear;

    always_comb begin
        load_secs = D_PGREEN;
        case (TimerMux)
            TM_SGREEN: load_secs = D_SGREEN;
            TM_YELLOW: load_secs = D_YELLOW;
            TM_AUX:    load_secs = D_AUX;
            default:   load_secs = D_PGREEN;
        endcase
    end

    // Prescaler only runs in COUNT, so every phase starts on a full second.
    assign clear = (state != TS_COUNT);

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .enable(enable),
        .tick  (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= TS_LOAD;
            Remaining <= '0;
            sel_q     <= TM_PGREEN;
            trigger   <= 1'b0;
        end else begin
            case (state)
                TS_LOAD: begin
                    Remaining <= load_secs;
                    sel_q     <= TimerMux;
                    trigger   <= 1'b0;
                    state     <= TS_COUNT;
                end
                TS_COUNT: begin
                    // A select change restarts the phase and outranks a coincident tick.
                    if (TimerMux != sel_q) begin
                        state <= TS_LOAD;
                    end else if (tick) begin
                        Remaining <= Remaining - 8'd1;
                        if (Remaining == 8'd1) begin
                            state   <= TS_FIRE;
                            trigger <= 1'b1;
                        end
                    end
                end
                TS_FIRE: begin
                    trigger <= 1'b0;
                    state   <= TS_LOAD;
                end
                default: begin
                    trigger <= 1'b0;
                    state   <= TS_LOAD;
                end
            endcase
        end
    end

    assign TimerState = state;

endmodule

// File: tb/tb_semaphore_timer.sv
// Self-checking bench for semaphore_timer against an elapsed-time phase model.
module tb_semaphore_timer;

    localparam int unsigned T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mux   = 2'b00;
    logic       en    = 1'b1;
    logic       trigger;
    logic [7:0] Remaining;
    logic [1:0] TimerState;

    logic [1:0] y_mux = 2'b10;
    logic       y_en  = 1'b1;
    logic       y_trigger;
    logic [7:0] y_rem;
    logic [1:0] y_state;

    int n_cmp = 0;
    int n_bad = 0;

    semaphore_timer #(
        .TICK_CYCLES(4), .T_PGREEN(3), .T_SGREEN(2), .T_YELLOW(1), .T_AUX(1)
    ) dut (
        .clock(clock), .reset(reset), .TimerMux(mux), .enable(en),
        .trigger(trigger), .Remaining(Remaining), .TimerState(TimerState)
    );

    semaphore_timer #(
        .TICK_CYCLES(4), .T_PGREEN(3), .T_SGREEN(2), .T_YELLOW(0), .T_AUX(1)
    ) dut_y0 (
        .clock(clock), .reset(reset), .TimerMux(y_mux), .enable(y_en),
        .trigger(y_trigger), .Remaining(y_rem), .TimerState(y_state)
    );

    always #5 clock = ~clock;

    // Reference model: a phase is (select, seconds, enabled cycles spent in it).
    bit         m_need_load;
    bit         m_firing;
    int         m_elapsed;
    int         m_dur;
    logic [1:0] m_sel;
    logic [7:0] m_rem;

    function automatic int dur_of(input logic [1:0] s);
        case (s)
            2'b00:   return 3;
            2'b01:   return 2;
            default: return 1;
        endcase
    endfunction

    task model_reset();
        m_need_load = 1; m_firing = 0; m_elapsed = 0; m_dur = 0;
        m_sel = 2'b00; m_rem = 8'd0;
    endtask

    task model_edge(input logic [1:0] s, input bit e);
        if (m_firing) begin
            m_firing = 0; m_need_load = 1;
        end else if (m_need_load) begin
            m_sel = s; m_dur = dur_of(s); m_elapsed = 0; m_need_load = 0;
            m_rem = 8'(m_dur);
        end else if (s != m_sel) begin
            m_need_load = 1;
        end else if (e) begin
            m_elapsed++;
            m_rem = 8'(m_dur - m_elapsed / T);
            if (m_elapsed == m_dur * T) m_firing = 1;
        end
    endtask

    function automatic logic [10:0] exp_word();
        return {m_firing, m_rem, m_firing ? 2'd2 : (m_need_load ? 2'd0 : 2'd1)};
    endfunction

    task step();
        @(posedge clock);
        if (!reset) model_edge(mux, en);
        #1;
    endtask

    task apply_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task test_reset();
        reset = 1'b1; mux = 2'b00; en = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({trigger, Remaining, TimerState} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=000", {trigger, Remaining, TimerState});
        end
        n_cmp++;
        if ({y_trigger, y_rem, y_state} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_state_y0 got=%h want=000", {y_trigger, y_rem, y_state});
        end
        #1 reset = 1'b0;
    endtask

    task test_basic_period();
        int first, second;
        logic [7:0] want_rem [4];
        want_rem = '{8'd3, 8'd2, 8'd1, 8'd0};
        first = -1; second = -1;
        mux = 2'b00; en = 1'b1;
        apply_reset();
        for (int e = 1; e <= 30; e++) begin
            step();
            n_cmp++;
            if ({trigger, Remaining, TimerState} !== exp_word()) begin
                n_bad++;
                $display("FAIL basic_model edge=%0d got=%h want=%h", e, {trigger, Remaining, TimerState}, exp_word());
            end
            if (trigger) begin
                if (first < 0) first = e; else if (second < 0) second = e;
            end
            if (e % 4 == 1 && e <= 13) begin
                n_cmp++;
                if (Remaining !== want_rem[e / 4]) begin
                    n_bad++;
                    $display("FAIL basic_remaining edge=%0d got=%0d want=%0d", e, Remaining, want_rem[e / 4]);
                end
            end
        end
        n_cmp++;
        if (first != 13 || second != 27) begin
            n_bad++;
            $display("FAIL basic_trigger_edges got=%0d,%0d want=13,27", first, second);
        end
    endtask

    task test_closed_loop();
        logic [1:0] seq [5];
        int want_iv [5];
        int t_prev, idx;
        seq = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
        want_iv = '{13, 6, 10, 6, 14};
        idx = 0; t_prev = 0;
        mux = seq[0]; en = 1'b1;
        apply_reset();
        for (int e = 1; e <= 80 && idx < 5; e++) begin
            step();
            n_cmp++;
            if ({trigger, Remaining, TimerState} !== exp_word()) begin
                n_bad++;
                $display("FAIL loop_model edge=%0d got=%h want=%h", e, {trigger, Remaining, TimerState}, exp_word());
            end
            if (trigger) begin
                n_cmp++;
                if (e - t_prev != want_iv[idx]) begin
                    n_bad++;
                    $display("FAIL loop_interval phase=%0d got=%0d want=%0d", idx, e - t_prev, want_iv[idx]);
                end
                t_prev = e;
                idx++;
                if (idx < 5) mux = seq[idx];
            end
        end
        n_cmp++;
        if (idx != 5) begin
            n_bad++;
            $display("FAIL loop_pulse_count got=%0d want=5", idx);
        end
    endtask

    task test_restart();
        int fire_edge;
        fire_edge = -1;
        mux = 2'b00; en = 1'b1;
        apply_reset();
        repeat (8) step();
        mux = 2'b01;
        step();  // edge 9 coincides with a tick
        n_cmp++;
        if ({trigger, Remaining, TimerState} !== {1'b0, 8'd2, 2'd0}) begin
            n_bad++;
            $display("FAIL restart_priority got=%h want=%h", {trigger, Remaining, TimerState}, {1'b0, 8'd2, 2'd0});
        end
        for (int e = 10; e <= 30; e++) begin
            step();
            n_cmp++;
            if ({trigger, Remaining, TimerState} !== exp_word()) begin
                n_bad++;
                $display("FAIL restart_model edge=%0d got=%h want=%h", e, {trigger, Remaining, TimerState}, exp_word());
            end
            if (trigger && fire_edge < 0) fire_edge = e;
        end
        n_cmp++;
        if (fire_edge != 18) begin
            n_bad++;
            $display("FAIL restart_fire_edge got=%0d want=18", fire_edge);
        end
    endtask

    task test_enable_freeze();
        int fire_edge;
        fire_edge = -1;
        mux = 2'b00; en = 1'b1;
        apply_reset();
        repeat (6) step();
        en = 1'b0;
        for (int e = 7; e <= 13; e++) begin
            step();
            n_cmp++;
            if ({trigger, Remaining, TimerState} !== {1'b0, 8'd2, 2'd1}) begin
                n_bad++;
                $display("FAIL freeze_hold edge=%0d got=%h want=%h", e, {trigger, Remaining, TimerState}, {1'b0, 8'd2, 2'd1});
            end
        end
        en = 1'b1;
        for (int e = 14; e <= 30 && fire_edge < 0; e++) begin
            step();
            if (trigger) fire_edge = e;
        end
        n_cmp++;
        if (fire_edge != 20) begin
            n_bad++;
            $display("FAIL freeze_fire_edge got=%0d want=20", fire_edge);
        end
        en = 1'b0;
        step();
        n_cmp++;
        if ({trigger, TimerState} !== {1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL fire_enable_low got=%h want=0", {trigger, TimerState});
        end
        step();
        n_cmp++;
        if ({trigger, Remaining, TimerState} !== {1'b0, 8'd3, 2'd1}) begin
            n_bad++;
            $display("FAIL load_enable_low got=%h want=%h", {trigger, Remaining, TimerState}, {1'b0, 8'd3, 2'd1});
        end
        en = 1'b1;
    endtask

    task test_reset_in_fire();
        int fire_edge, early;
        fire_edge = -1; early = 0;
        mux = 2'b00; en = 1'b1;
        apply_reset();
        for (int e = 1; e <= 30 && !trigger; e++) step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({trigger, Remaining, TimerState} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_in_fire got=%h want=000", {trigger, Remaining, TimerState});
        end
        @(posedge clock);
        #1 reset = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (trigger && e < 13) early++;
            if (trigger && fire_edge < 0) fire_edge = e;
        end
        n_cmp++;
        if (early != 0 || fire_edge != 13) begin
            n_bad++;
            $display("FAIL reset_restart got early=%0d fire=%0d want early=0 fire=13", early, fire_edge);
        end
    endtask

    task test_yellow_zero();
        int t_prev, pulses;
        t_prev = -1; pulses = 0;
        mux = 2'b00; en = 1'b1;
        apply_reset();
        for (int e = 1; e <= 30; e++) begin
            step();
            if (y_trigger) begin
                n_cmp++;
                if ((t_prev < 0 && e != 5) || (t_prev >= 0 && e - t_prev != 6)) begin
                    n_bad++;
                    $display("FAIL yellow_zero_period edge=%0d prev=%0d want first=5 period=6", e, t_prev);
                end
                t_prev = e; pulses++;
            end
        end
        n_cmp++;
        if (pulses != 5) begin
            n_bad++;
            $display("FAIL yellow_zero_pulses got=%0d want=5", pulses);
        end
    endtask

    task test_random();
        mux = 2'($urandom_range(0, 3)); en = 1'b1;
        apply_reset();
        for (int e = 1; e <= 2000; e++) begin
            step();
            n_cmp++;
            if ({trigger, Remaining, TimerState} !== exp_word()) begin
                n_bad++;
                $display("FAIL random_model edge=%0d got=%h want=%h", e, {trigger, Remaining, TimerState}, exp_word());
            end
            if (trigger || $urandom_range(0, 39) == 0) mux = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) en = ~en;
        end
        en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_period();
        test_closed_loop();
        test_restart();
        test_enable_freeze();
        test_reset_in_fire();
        test_yellow_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
